sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
//  Single-clock FIFO: parametrised depth/width, programmable almost-full/almost-empty
//  thresholds, occupancy count, selectable standard or first-word-fall-through (FWFT)
//  read mode, synchronous flush, sticky overflow/underflow flags.
//  Same-domain companion to the async FIFO; used where producer and consumer share clk.
// PARAMETERS
//  PTR_WIDTH     4   pointer width incl. wrap bit; DEPTH = 2**(PTR_WIDTH-1)
//  DATA_WIDTH    32  data word width
//  AFULL_THRESH  6   almost_full asserted when count >= AFULL_THRESH (1..DEPTH-1)
//  AEMPTY_THRESH 1   almost_empty asserted when count <= AEMPTY_THRESH (0..DEPTH-2)
//  FWFT          0   0 = standard registered read; 1 = first-word-fall-through
// PORTS
//  clk          in  1           clock
//  rst_n        in  1           asynchronous reset, active low
//  clr          in  1           synchronous flush; empties FIFO, clears error flags
//  wren         in  1           write request
//  wdata        in  DATA_WIDTH  write data
//  rden         in  1           read request (FWFT: pop/acknowledge of head word)
//  rdata        out DATA_WIDTH  read data
//  wfull        out 1           count == DEPTH
//  rempty       out 1           count == 0
//  almost_full  out 1           count >= AFULL_THRESH
//  almost_empty out 1           count <= AEMPTY_THRESH
//  count        out PTR_WIDTH   occupancy, 0..DEPTH
//  wr_err       out 1           sticky: wren seen while wfull
//  rd_err       out 1           sticky: rden seen while rempty
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers 0, count 0, rempty 1, wfull 0,
//    almost_empty 1, almost_full 0, rdata 0, wr_err 0, rd_err 0. Memory not reset.
//  - Pointers are PTR_WIDTH-bit binary; low ADDR_WIDTH = PTR_WIDTH-1 bits address the
//    flop array, MSB is the wrap bit. Increment wraps naturally at 2**PTR_WIDTH.
//  - Write accepted iff wren && !wfull; read accepted iff rden && !rempty. Flags sampled
//    at the edge are the pre-edge values; a read does not free space for a same-cycle
//    write when full, and a write does not supply data for a same-cycle read when empty.
//  - count: +1 write only, -1 read only, unchanged when both or neither accepted.
//  - All flags decode from registered count/pointers; no comb path from wren/rden.
//  - Write at edge N -> count/flags updated after edge N; rempty low from cycle N+1.
//  - Standard (FWFT=0): accepted read at edge M loads rdata from head after edge M
//    (1-cycle latency); rdata holds its value otherwise.
//  - FWFT=1: rdata = mem[rdaddr] combinationally while !rempty; word written at edge N
//    visible on rdata in cycle N+1; accepted rden advances to next word after the edge.
//    rdata is don't-care while rempty.
//  - Rejected wren sets wr_err; rejected rden sets rd_err; pointers/count unchanged.
//  - clr: after edge, pointers 0, count 0, rempty 1, errors 0; clr has priority over
//    any same-cycle wren/rden (neither accepted, no error set). rdata unaffected (FWFT=0).
//  - Reset mid-operation discards all contents; no partial state survives.
//  - Elaboration $fatal if thresholds are out of the stated ranges or PTR_WIDTH < 2.
// TESTING  (PTR_WIDTH=3 -> DEPTH 4, DATA_WIDTH=8, AFULL=3, AEMPTY=1)
//  - Reset: assert rst_n=0 mid-cycle -> immediately rempty=1, wfull=0, count=0, almost_empty=1.
//  - Fill/drain FWFT=0: write 0x11,0x22,0x33,0x44 -> wfull=1, count=4; 5th wren -> wr_err=1,
//    count stays 4; 4 reads -> rdata 0x11..0x44 each one cycle after rden; rempty=1.
//  - FWFT=1: write 0xA5 into empty FIFO -> next cycle rempty=0, rdata=0xA5 without rden.
//  - Simultaneous: count=2, wren+rden -> count stays 2, order preserved; at full, wren+rden
//    -> read only, wr_err=1, count 3; at empty, wren+rden -> write only, rd_err=1, count 1.
//  - Wrap: 10 write/read pairs with incrementing data -> pointers wrap, data FIFO-ordered,
//    almost_full toggles at count 3, almost_empty at count 1.
//  - clr with count=3 and wren high -> count 0, rempty=1, errors 0, write dropped.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with thresholds, occupancy, optional FWFT read, flush and sticky errors.
// Latency: write visible after 1 edge; standard read data 1 cycle after rden, FWFT head combinational.
// Backpressure: wren ignored while wfull (sets wr_err), rden ignored while rempty (sets rd_err).
module sync_fifo_ctrl #(
    parameter int PTR_WIDTH     = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH-1:0]  count,
    output logic                  wr_err,
    output logic                  rd_err
);
    localparam int ADDR_WIDTH = PTR_WIDTH - 1;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    localparam logic [PTR_WIDTH-1:0] L_DEPTH  = PTR_WIDTH'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] L_AFULL  = PTR_WIDTH'(AFULL_THRESH);
    localparam logic [PTR_WIDTH-1:0] L_AEMPTY = PTR_WIDTH'(AEMPTY_THRESH);

    if (PTR_WIDTH < 2) begin : g_bad_ptr
        $fatal(1, "sync_fifo_ctrl: PTR_WIDTH must be >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH - 1) begin : g_bad_afull
        $fatal(1, "sync_fifo_ctrl: AFULL_THRESH out of range");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 2) begin : g_bad_aempty
        $fatal(1, "sync_fifo_ctrl: AEMPTY_THRESH out of range");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_wrptr;
    logic [PTR_WIDTH-1:0]  r_rdptr;
    logic                  r_wr_err;
    logic                  r_rd_err;

    logic [PTR_WIDTH-1:0]  w_count;
    logic [ADDR_WIDTH-1:0] w_rdaddr;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Occupancy is the pointer distance; the wrap bit makes full (== DEPTH) distinct from empty.
    assign w_count  = r_wrptr - r_rdptr;
    assign w_rdaddr = r_rdptr[ADDR_WIDTH-1:0];

    assign count        = w_count;
    assign wfull        = (w_count == L_DEPTH);
    assign rempty       = (w_count == '0);
    assign almost_full  = (w_count >= L_AFULL);
    assign almost_empty = (w_count <= L_AEMPTY);
    assign wr_err       = r_wr_err;
    assign rd_err       = r_rd_err;

    assign w_wr_acc = wren && !wfull && !clr;
    assign w_rd_acc = rden && !rempty && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrptr  <= '0;
            r_rdptr  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else if (clr) begin
            r_wrptr  <= '0;
            r_rdptr  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_wr_acc) r_wrptr <= r_wrptr + 1'b1;
            if (w_rd_acc) r_rdptr <= r_rdptr + 1'b1;
            if (wren && wfull) r_wr_err <= 1'b1;
            if (rden && rempty) r_rd_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wrptr[ADDR_WIDTH-1:0]] <= wdata;
    end

    if (FWFT != 0) begin : g_fwft
        assign rdata = rempty ? '0 : r_mem[w_rdaddr];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_rdata;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        r_rdata <= '0;
            else if (w_rd_acc) r_rdata <= r_mem[w_rdaddr];
        end
        assign rdata = r_rdata;
    end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: standard and FWFT instances share stimulus and are
// compared against a queue-based reference of the FIFO contract.
module tb_sync_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, clr, wren, rden;
    logic [7:0] wdata;

    logic [7:0] rdata_s, rdata_f;
    logic       wfull_s, rempty_s, afull_s, aempty_s, werr_s, rerr_s;
    logic       wfull_f, rempty_f, afull_f, aempty_f, werr_f, rerr_f;
    logic [2:0] count_s, count_f;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.PTR_WIDTH(3), .DATA_WIDTH(8), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(0)) u_dut_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .wdata(wdata), .rden(rden),
        .rdata(rdata_s), .wfull(wfull_s), .rempty(rempty_s), .almost_full(afull_s),
        .almost_empty(aempty_s), .count(count_s), .wr_err(werr_s), .rd_err(rerr_s));

    sync_fifo_ctrl #(.PTR_WIDTH(3), .DATA_WIDTH(8), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1)) u_dut_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .wdata(wdata), .rden(rden),
        .rdata(rdata_f), .wfull(wfull_f), .rempty(rempty_f), .almost_full(afull_f),
        .almost_empty(aempty_f), .count(count_f), .wr_err(werr_f), .rd_err(rerr_f));

    logic [7:0] q[$];
    logic [7:0] m_rd;
    logic       m_werr, m_rerr;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_rd   = 8'h00;
        m_werr = 1'b0;
        m_rerr = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic r, input logic c, input logic [7:0] d);
        bit full, empty;
        if (c) begin
            q.delete();
            m_werr = 1'b0;
            m_rerr = 1'b0;
        end else begin
            full  = (q.size() == 4);
            empty = (q.size() == 0);
            if (w && full)  m_werr = 1'b1;
            if (r && empty) m_rerr = 1'b1;
            if (r && !empty) m_rd = q.pop_front();
            if (w && !full)  q.push_back(d);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count",        32'(count_s),  32'(n));
        chk("count_fwft",   32'(count_f),  32'(n));
        chk("rempty",       32'(rempty_s), 32'(n == 0));
        chk("wfull",        32'(wfull_s),  32'(n == 4));
        chk("almost_full",  32'(afull_s),  32'(n >= 3));
        chk("almost_empty", 32'(aempty_s), 32'(n <= 1));
        chk("wr_err",       32'(werr_s),   32'(m_werr));
        chk("rd_err",       32'(rerr_s),   32'(m_rerr));
        chk("rdata_std",    32'(rdata_s),  32'(m_rd));
        chk("fwft_flags", {28'd0, wfull_f, rempty_f, afull_f, aempty_f},
            {28'd0, 1'(n == 4), 1'(n == 0), 1'(n >= 3), 1'(n <= 1)});
        chk("fwft_errs", {30'd0, werr_f, rerr_f}, {30'd0, m_werr, m_rerr});
        if (n != 0) chk("rdata_fwft", 32'(rdata_f), 32'(q[0]));
    endtask

    // Inputs are applied at the falling edge, held across one rising edge, then checked.
    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
        wren = w; rden = r; clr = c; wdata = d;
        @(posedge clk);
        model_step(w, r, c, d);
        @(negedge clk);
        wren = 1'b0; rden = 1'b0; clr = 1'b0;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; wren = 1'b0; rden = 1'b0; wdata = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Fill to full, overflow once, then drain in order.
        step(1, 0, 0, 8'h11); step(1, 0, 0, 8'h22); step(1, 0, 0, 8'h33); step(1, 0, 0, 8'h44);
        step(1, 0, 0, 8'h55);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h00);

        // Fall-through head visible without a read request.
        step(1, 0, 0, 8'hA5);
        step(0, 1, 0, 8'h00);

        // Simultaneous read/write at mid, full and empty occupancy.
        step(1, 0, 0, 8'h01); step(1, 0, 0, 8'h02);
        step(1, 1, 0, 8'h03);
        step(1, 0, 0, 8'h04); step(1, 0, 0, 8'h05);
        step(1, 1, 0, 8'h06);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h07);
        step(0, 0, 1, 8'h00);

        // Pointer wrap with occupancy sweeping the threshold boundaries.
        step(1, 0, 0, 8'h80);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 8'(2 * i));
            step(1, 0, 0, 8'(2 * i + 1));
            step(0, 1, 0, 8'h00);
            step(0, 1, 0, 8'h00);
        end

        // Flush at count 3 with an error pending and a write request in the same cycle.
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h60 + i));
        step(0, 1, 0, 8'h00);
        step(1, 0, 1, 8'h77);

        // Asynchronous reset asserted mid-cycle with data held.
        step(1, 0, 0, 8'h91); step(1, 0, 0, 8'h92);
        step(0, 1, 0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_rempty", 32'(rempty_s), 32'd1);
        chk("arst_wfull",  32'(wfull_s),  32'd0);
        chk("arst_count",  32'(count_s),  32'd0);
        chk("arst_aempty", 32'(aempty_s), 32'd1);
        chk("arst_rdata",  32'(rdata_s),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Randomised traffic alternating between fill-biased and drain-biased phases.
        for (int i = 0; i < 800; i++) begin
            int pw;
            pw = ((i / 40) % 2 == 0) ? 75 : 30;
            step(1'($urandom_range(99) < pw), 1'($urandom_range(99) < 100 - pw),
                 1'($urandom_range(59) == 0), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
